expr_tx: RTL

//  Character-stream generator for the expression protocol consumed by verify.

---
 rtl/expr_tx_if.sv | 22 ++
 rtl/expr_tx.sv | 125 ++++++++++++
 2 files changed

// File: rtl/expr_tx_if.sv
// Handshake bundle between a frame requester and the expression character generator.
// The master side requests frames; the slave side produces the paced character stream.
interface expr_tx_if;
   logic        start;
   logic [15:0] op_a;
   logic [15:0] op_b;
   logic        op_sub;
   logic [7:0]  ascii_char;
   logic        char_valid;
   logic        busy;
   logic        done;

   modport master (
      output start, op_a, op_b, op_sub,
      input  ascii_char, char_valid, busy, done
   );

   modport slave (
      input  start, op_a, op_b, op_sub,
      output ascii_char, char_valid, busy, done
   );
endinterface

// File: rtl/expr_tx.sv
// Emits "{AAAA+BBBB}" / "{AAAA-BBBB}" as uppercase hex ASCII, one character per baud slot,
// optionally framed by NUL pads; operands are latched when the frame is accepted.
module expr_tx #(
   parameter int UART_TX_baud = 20,
   parameter int freq         = 200,
   parameter bit PAD          = 1'b1
) (
   input  logic     clk,
   input  logic     rst_n,
   expr_tx_if.slave bus
);
   localparam int TR  = freq / UART_TX_baud;
   localparam int NCH = PAD ? 13 : 11;
   localparam int CW  = $clog2(TR);
   localparam logic [CW-1:0] BAUD_LAST = CW'(TR - 1);
   localparam logic [3:0]    SLOT_LAST = 4'(NCH - 1);

   typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

   state_t        state_q, state_d;
   logic [3:0]    slot_q, slot_d;
   logic [CW-1:0] baud_q, baud_d;
   logic [15:0]   a_q, a_d;
   logic [15:0]   b_q, b_d;
   logic          sub_q, sub_d;
   logic [7:0]    char_q, char_d;

   function automatic logic [7:0] hex_char(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
   endfunction

   // With PAD the frame body shifts by one; slot 0 then maps to pos 15 and slot 12 to
   // pos 11, both of which fall through to the NUL default.
   function automatic logic [7:0] frame_char(input logic [3:0] slot, input logic [15:0] a,
                                             input logic [15:0] b, input logic sub);
      logic [3:0] pos;
      logic [7:0] c;
      pos = PAD ? (slot - 4'd1) : slot;
      c   = 8'h00;
      case (pos)
         4'd0:    c = 8'h7B;
         4'd1:    c = hex_char(a[15:12]);
         4'd2:    c = hex_char(a[11:8]);
         4'd3:    c = hex_char(a[7:4]);
         4'd4:    c = hex_char(a[3:0]);
         4'd5:    c = sub ? 8'h2D : 8'h2B;
         4'd6:    c = hex_char(b[15:12]);
         4'd7:    c = hex_char(b[11:8]);
         4'd8:    c = hex_char(b[7:4]);
         4'd9:    c = hex_char(b[3:0]);
         4'd10:   c = 8'h7D;
         default: c = 8'h00;
      endcase
      return c;
   endfunction

   always_comb begin
      state_d = state_q;
      slot_d  = slot_q;
      baud_d  = baud_q;
      a_d     = a_q;
      b_d     = b_q;
      sub_d   = sub_q;
      char_d  = char_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               a_d     = bus.op_a;
               b_d     = bus.op_b;
               sub_d   = bus.op_sub;
               slot_d  = 4'd0;
               baud_d  = '0;
               char_d  = frame_char(4'd0, bus.op_a, bus.op_b, bus.op_sub);
               state_d = SEND;
            end
         end
         SEND: begin
            if (baud_q == BAUD_LAST) begin
               baud_d = '0;
               if (slot_q == SLOT_LAST) begin
                  char_d  = 8'h00;
                  state_d = DONE;
               end else begin
                  slot_d = slot_q + 4'd1;
                  char_d = frame_char(slot_q + 4'd1, a_q, b_q, sub_q);
               end
            end else begin
               baud_d = baud_q + CW'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            char_d  = 8'h00;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         slot_q  <= 4'd0;
         baud_q  <= '0;
         a_q     <= 16'h0000;
         b_q     <= 16'h0000;
         sub_q   <= 1'b0;
         char_q  <= 8'h00;
      end else begin
         state_q <= state_d;
         slot_q  <= slot_d;
         baud_q  <= baud_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sub_q   <= sub_d;
         char_q  <= char_d;
      end
   end

   assign bus.ascii_char = char_q;
   assign bus.char_valid = (state_q == SEND) && (baud_q == BAUD_LAST);
   assign bus.busy       = (state_q == SEND);
   assign bus.done       = (state_q == DONE);
endmodule
